// File: rtl/accumulate_arbiter.sv
// Round-robin arbiter sharing one accumulator between N requesters, one whole burst at a time.
// Build option: define ACCUMULATE_ARBITER_FIXED_PRIORITY_EN for fixed priority (index 0 highest).
module accumulate_arbiter #(
  parameter int N    = 4,
  parameter int ARGW = 32,
  parameter int RESW = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_stb,
  input  logic [N*ARGW-1:0]      req_dat,
  output logic [N-1:0]           req_rdy,
  output logic [N-1:0]           rsp_stb,
  output logic [RESW-1:0]        rsp_dat,
  input  logic [N-1:0]           rsp_rdy,
  output logic                   acc_stb,
  output logic [ARGW-1:0]        acc_dat,
  input  logic                   acc_rdy,
  input  logic                   acc_res_stb,
  input  logic [RESW-1:0]        acc_res_dat,
  output logic                   acc_res_rdy,
  output logic [1:0]             dbg_state,
  output logic [$clog2(N)-1:0]   dbg_ptr
);

  // Handshake: every stb/rdy pair transfers on a rising edge where both are high;
  // a strobe holds its data stable until accepted, and stb low for one cycle ends a burst.

  localparam int GW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [GW-1:0] gnt, gnt_n;
  logic [GW-1:0] ptr, ptr_n;
  logic          seen, seen_n;

  logic [GW-1:0] gnt_inc;
  logic [GW-1:0] cand;
  logic [GW-1:0] pick_idx;
  logic          pick_found;

  assign gnt_inc = (gnt == GW'(N - 1)) ? '0 : gnt + 1'b1;

  // Requester selection scans from ptr (or from 0 in fixed-priority builds).
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = 0; k < N; k++) begin
`ifdef ACCUMULATE_ARBITER_FIXED_PRIORITY_EN
      cand = GW'(k);
`else
      cand = GW'((int'(ptr) + k) % N);
`endif
      if (!pick_found && req_stb[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      seen  <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      seen  <= seen_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = ptr;
    seen_n  = seen;
    case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_n   = pick_idx;
          seen_n  = 1'b0;
          state_n = BURST;
        end
      end
      BURST: begin
        if (req_stb[gnt] && acc_rdy) begin
          seen_n = 1'b1;
        end
        // A withdrawn grant with no beats never produces a result, so skip DRAIN.
        if (!req_stb[gnt]) begin
          if (seen) begin
            state_n = DRAIN;
          end else begin
            state_n = IDLE;
            ptr_n   = gnt_inc;
          end
        end
      end
      DRAIN: begin
        if (acc_res_stb && rsp_rdy[gnt]) begin
          state_n = IDLE;
          ptr_n   = gnt_inc;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    req_rdy     = '0;
    rsp_stb     = '0;
    acc_stb     = 1'b0;
    acc_res_rdy = 1'b0;
    case (state)
      BURST: begin
        acc_stb      = req_stb[gnt];
        req_rdy[gnt] = acc_rdy;
      end
      DRAIN: begin
        rsp_stb[gnt] = acc_res_stb;
        acc_res_rdy  = rsp_rdy[gnt];
      end
      default: begin
      end
    endcase
  end

  assign acc_dat   = req_dat[int'(gnt)*ARGW +: ARGW];
  assign rsp_dat   = acc_res_dat;
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_accumulate_arbiter.sv
// Directed bench for accumulate_arbiter: producer queues, a behavioural accumulator and a log monitor.
module tb_accumulate_arbiter;

  localparam int N    = 4;
  localparam int ARGW = 32;
  localparam int RESW = 40;
  localparam int BUDGET = 300;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         req_stb;
  logic [N*ARGW-1:0]    req_dat;
  logic [N-1:0]         req_rdy;
  logic [N-1:0]         rsp_stb;
  logic [RESW-1:0]      rsp_dat;
  logic [N-1:0]         rsp_rdy;
  logic                 acc_stb;
  logic [ARGW-1:0]      acc_dat;
  logic                 acc_rdy;
  logic                 acc_res_stb;
  logic [RESW-1:0]      acc_res_dat;
  logic                 acc_res_rdy;
  logic [1:0]           dbg_state;
  logic [$clog2(N)-1:0] dbg_ptr;

  accumulate_arbiter #(.N(N), .ARGW(ARGW), .RESW(RESW)) dut (
    .clk(clk), .rst(rst),
    .req_stb(req_stb), .req_dat(req_dat), .req_rdy(req_rdy),
    .rsp_stb(rsp_stb), .rsp_dat(rsp_dat), .rsp_rdy(rsp_rdy),
    .acc_stb(acc_stb), .acc_dat(acc_dat), .acc_rdy(acc_rdy),
    .acc_res_stb(acc_res_stb), .acc_res_dat(acc_res_dat), .acc_res_rdy(acc_res_rdy),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- producers ----------------
  typedef struct packed {
    logic [ARGW-1:0] dat;
    logic            last;
    logic            wd;
  } beat_t;

  beat_t        prod_q [N][$];
  logic [N-1:0] gap;

  initial begin
    req_stb = '0;
    req_dat = '0;
    gap     = '0;
    forever begin
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) begin
        if (prod_q[i].size() > 0 && !gap[i]) begin
          req_stb[i] = 1'b1;
          req_dat[i*ARGW +: ARGW] = prod_q[i][0].dat;
        end else begin
          req_stb[i] = 1'b0;
          req_dat[i*ARGW +: ARGW] = '0;
        end
      end
      #4;
      for (int i = 0; i < N; i++) begin
        if (!rst) begin
          prod_q[i].delete();
          gap[i] = 1'b0;
        end else if (gap[i]) begin
          gap[i] = 1'b0;
        end else if (req_stb[i] && prod_q[i].size() > 0 && (req_rdy[i] || prod_q[i][0].wd)) begin
          if (prod_q[i][0].last || prod_q[i][0].wd) gap[i] = 1'b1;
          void'(prod_q[i].pop_front());
        end
      end
    end
  end

  // ---------------- behavioural accumulator ----------------
  logic signed [RESW-1:0] m_sum;
  logic [RESW-1:0]        m_res;
  logic                   m_inb;
  logic                   m_pend;
  int                     m_dly;

  initial begin
    acc_res_stb = 1'b0;
    acc_res_dat = '0;
    m_sum = '0; m_res = '0; m_inb = 1'b0; m_pend = 1'b0; m_dly = 0;
    forever begin
      @(posedge clk); #3;
      acc_res_stb = m_pend && (m_dly == 0);
      acc_res_dat = acc_res_stb ? m_res : '0;
      #3;
      if (!rst) begin
        m_sum = '0; m_inb = 1'b0; m_pend = 1'b0; m_dly = 0;
      end else begin
        if (acc_res_stb && acc_res_rdy) m_pend = 1'b0;
        if (m_dly > 0) m_dly--;
        if (acc_stb && acc_rdy) begin
          m_sum = m_sum + RESW'($signed(acc_dat));
          m_inb = 1'b1;
        end else if (!acc_stb && m_inb) begin
          m_res  = m_sum;
          m_pend = 1'b1;
          m_dly  = 2;
          m_sum  = '0;
          m_inb  = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / logs ----------------
  int              cyc = 0;
  int              gnt_log [$];
  int              rsp_who [$];
  logic [RESW-1:0] rsp_val [$];
  int              rsp_cyc [$];
  int              multi_cnt, gap_viol, beat_cnt, first_acc, first_req;
  int              first_rdy [N];
  logic [N-1:0]    rsp_mask;
  logic            saw_burst;
  logic            in_burst;
  int              prev_who;

  initial begin
    in_burst = 1'b0;
    prev_who = -1;
    forever begin
      @(posedge clk);
      cyc++;
      #5;
      if (!rst) begin
        in_burst = 1'b0;
      end else begin
        if ($countones(req_rdy) > 1 || $countones(rsp_stb) > 1) multi_cnt++;
        if (acc_stb && acc_rdy) begin
          int who;
          who = -1;
          for (int i = 0; i < N; i++) if (req_stb[i] && req_rdy[i]) who = i;
          beat_cnt++;
          if (!in_burst) gnt_log.push_back(who);
          else if (who != prev_who) gap_viol++;
          in_burst = 1'b1;
          prev_who = who;
        end
        if (!acc_stb) in_burst = 1'b0;
        rsp_mask = rsp_mask | rsp_stb;
        for (int i = 0; i < N; i++) begin
          if (rsp_stb[i] && rsp_rdy[i]) begin
            rsp_who.push_back(i);
            rsp_val.push_back(rsp_dat);
            rsp_cyc.push_back(cyc);
          end
          if (req_rdy[i] && first_rdy[i] < 0) first_rdy[i] = cyc;
        end
        if (acc_stb && first_acc < 0) first_acc = cyc;
        if (req_stb != '0 && first_req < 0) first_req = cyc;
        if (dbg_state == 2'd1) saw_burst = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); rsp_who.delete(); rsp_val.delete(); rsp_cyc.delete();
    multi_cnt = 0; gap_viol = 0; beat_cnt = 0; first_acc = -1; first_req = -1;
    for (int i = 0; i < N; i++) first_rdy[i] = -1;
    rsp_mask = '0; saw_burst = 1'b0;
  endtask

  task automatic push_beat(input int r, input logic [ARGW-1:0] d, input logic last, input logic wd);
    beat_t b;
    b.dat = d; b.last = last; b.wd = wd;
    prod_q[r].push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < BUDGET && rsp_who.size() < n; k++) tick();
  endtask

  // ---------------- scenarios ----------------
  int              exp_who [$];
  logic [RESW-1:0] exp_q [$];
  int              exp_gnt [$];

  task automatic test_reset();
    rst = 1'b0; acc_rdy = 1'b1; rsp_rdy = '1;
    clear_logs();
    tick(); tick();
    checks++; if (acc_stb !== 1'b0) begin errors++; $display("FAIL reset_acc_stb got %b exp 0", acc_stb); end
    checks++; if (req_rdy !== '0) begin errors++; $display("FAIL reset_req_rdy got %b exp 0", req_rdy); end
    checks++; if (rsp_stb !== '0) begin errors++; $display("FAIL reset_rsp_stb got %b exp 0", rsp_stb); end
    checks++; if (acc_res_rdy !== 1'b0) begin errors++; $display("FAIL reset_acc_res_rdy got %b exp 0", acc_res_rdy); end
    rst = 1'b1;
    tick();
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    checks++; if (dbg_ptr !== 2'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", dbg_ptr); end
  endtask

  task automatic test_single();
    clear_logs();
    push_beat(1, 5, 1'b0, 1'b0);
    push_beat(1, -3, 1'b0, 1'b0);
    push_beat(1, 10, 1'b1, 1'b0);
    wait_rsp(1);
    tick(); tick();
    checks++; if (first_acc - first_req !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", first_acc - first_req); end
    checks++; if (rsp_who.size() !== 1) begin errors++; $display("FAIL single_count got %0d exp 1", rsp_who.size()); end
    checks++; if (rsp_who[0] !== 1) begin errors++; $display("FAIL single_who got %0d exp 1", rsp_who[0]); end
    checks++; if (rsp_val[0] !== 40'd12) begin errors++; $display("FAIL single_sum got %0h exp %0h", rsp_val[0], 40'd12); end
    checks++; if (rsp_mask !== 4'b0010) begin errors++; $display("FAIL single_rsp_mask got %b exp 0010", rsp_mask); end
  endtask

  task automatic test_two_requesters();
    do_reset();
    clear_logs();
    push_beat(0, 3, 1'b0, 1'b0); push_beat(0, 4, 1'b1, 1'b0);
    push_beat(2, 1, 1'b0, 1'b0); push_beat(2, -2, 1'b1, 1'b0);
    exp_who = '{0, 2};
    exp_q   = '{40'd7, 40'hFF_FFFF_FFFF};
    wait_rsp(2);
    tick();
    checks++; if (rsp_who.size() !== 2) begin errors++; $display("FAIL two_count got %0d exp 2", rsp_who.size()); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (rsp_who[k] !== exp_who[k]) begin errors++; $display("FAIL two_who[%0d] got %0d exp %0d", k, rsp_who[k], exp_who[k]); end
      checks++; if (rsp_val[k] !== exp_q[k]) begin errors++; $display("FAIL two_sum[%0d] got %0h exp %0h", k, rsp_val[k], exp_q[k]); end
    end
    checks++; if (dbg_ptr !== 2'd3) begin errors++; $display("FAIL two_ptr got %0d exp 3", dbg_ptr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_logs();
    for (int r = 0; r < N; r++) begin
      push_beat(r, 1, 1'b0, 1'b0); push_beat(r, 1, 1'b1, 1'b0);
    end
    push_beat(0, 1, 1'b0, 1'b0); push_beat(0, 1, 1'b1, 1'b0);
    exp_gnt = '{0, 1, 2, 3, 0};
    wait_rsp(5);
    checks++; if (gnt_log.size() !== 5) begin errors++; $display("FAIL b2b_gnt_count got %0d exp 5", gnt_log.size()); end
    checks++; if (rsp_who.size() !== 5) begin errors++; $display("FAIL b2b_rsp_count got %0d exp 5", rsp_who.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (gnt_log[k] !== exp_gnt[k]) begin errors++; $display("FAIL b2b_gnt[%0d] got %0d exp %0d", k, gnt_log[k], exp_gnt[k]); end
      checks++; if (rsp_who[k] !== exp_gnt[k]) begin errors++; $display("FAIL b2b_who[%0d] got %0d exp %0d", k, rsp_who[k], exp_gnt[k]); end
      checks++; if (rsp_val[k] !== 40'd2) begin errors++; $display("FAIL b2b_sum[%0d] got %0h exp 2", k, rsp_val[k]); end
    end
    checks++; if (multi_cnt !== 0) begin errors++; $display("FAIL b2b_multi_grant got %0d exp 0", multi_cnt); end
    checks++; if (gap_viol !== 0) begin errors++; $display("FAIL b2b_burst_gap got %0d exp 0", gap_viol); end
  endtask

  task automatic test_rsp_stall();
    clear_logs();
    rsp_rdy[0] = 1'b0;
    push_beat(0, 2, 1'b0, 1'b0); push_beat(0, 3, 1'b1, 1'b0);
    for (int k = 0; k < BUDGET && gnt_log.size() < 1; k++) tick();
    push_beat(1, 6, 1'b1, 1'b0);
    for (int k = 0; k < BUDGET && !rsp_mask[0]; k++) tick();
    for (int k = 0; k < 5; k++) tick();
    checks++; if (rsp_stb[0] !== 1'b1) begin errors++; $display("FAIL stall_rsp_held got %b exp 1", rsp_stb[0]); end
    checks++; if (first_rdy[1] !== -1) begin errors++; $display("FAIL stall_rdy1_early got cycle %0d exp none", first_rdy[1]); end
    rsp_rdy[0] = 1'b1;
    exp_who = '{0, 1};
    exp_q   = '{40'd5, 40'd6};
    wait_rsp(2);
    checks++; if (rsp_who.size() !== 2) begin errors++; $display("FAIL stall_count got %0d exp 2", rsp_who.size()); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (rsp_who[k] !== exp_who[k]) begin errors++; $display("FAIL stall_who[%0d] got %0d exp %0d", k, rsp_who[k], exp_who[k]); end
      checks++; if (rsp_val[k] !== exp_q[k]) begin errors++; $display("FAIL stall_sum[%0d] got %0h exp %0h", k, rsp_val[k], exp_q[k]); end
    end
    checks++; if (!(first_rdy[1] > rsp_cyc[0])) begin errors++; $display("FAIL stall_rdy1_order got %0d exp after %0d", first_rdy[1], rsp_cyc[0]); end
  endtask

  task automatic test_withdraw();
    clear_logs();
    acc_rdy = 1'b0;
    push_beat(3, 9, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) tick();
    checks++; if (saw_burst !== 1'b1) begin errors++; $display("FAIL wd_granted got %b exp 1", saw_burst); end
    checks++; if (rsp_mask !== '0) begin errors++; $display("FAIL wd_rsp_mask got %b exp 0000", rsp_mask); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL wd_state got %0d exp 0", dbg_state); end
    checks++; if (dbg_ptr !== 2'd0) begin errors++; $display("FAIL wd_ptr got %0d exp 0", dbg_ptr); end
    acc_rdy = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    clear_logs();
    push_beat(2, 1, 1'b0, 1'b0); push_beat(2, 2, 1'b0, 1'b0);
    push_beat(2, 3, 1'b0, 1'b0); push_beat(2, 4, 1'b1, 1'b0);
    for (int k = 0; k < BUDGET && beat_cnt < 2; k++) tick();
    checks++; if (acc_stb !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", acc_stb); end
    rst = 1'b0;
    #1;
    checks++; if (acc_stb !== 1'b0) begin errors++; $display("FAIL mid_acc_stb got %b exp 0", acc_stb); end
    checks++; if (req_rdy !== '0) begin errors++; $display("FAIL mid_req_rdy got %b exp 0", req_rdy); end
    checks++; if (rsp_stb !== '0 || acc_res_rdy !== 1'b0) begin errors++; $display("FAIL mid_rsp got %b/%b exp 0/0", rsp_stb, acc_res_rdy); end
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    clear_logs();
    push_beat(2, 4, 1'b0, 1'b0); push_beat(2, 4, 1'b1, 1'b0);
    wait_rsp(1);
    checks++; if (rsp_who.size() !== 1) begin errors++; $display("FAIL mid_count got %0d exp 1", rsp_who.size()); end
    checks++; if (rsp_who[0] !== 2) begin errors++; $display("FAIL mid_who got %0d exp 2", rsp_who[0]); end
    checks++; if (rsp_val[0] !== 40'd8) begin errors++; $display("FAIL mid_sum got %0h exp 8", rsp_val[0]); end
  endtask

  task automatic test_priority_mode();
    do_reset();
    clear_logs();
    push_beat(1, 1, 1'b1, 1'b0); push_beat(1, 2, 1'b1, 1'b0); push_beat(1, 3, 1'b1, 1'b0);
    push_beat(3, 7, 1'b1, 1'b0);
`ifdef ACCUMULATE_ARBITER_FIXED_PRIORITY_EN
    exp_who = '{1, 1, 1, 3};
    exp_q   = '{40'd1, 40'd2, 40'd3, 40'd7};
`else
    exp_who = '{1, 3, 1, 1};
    exp_q   = '{40'd1, 40'd7, 40'd2, 40'd3};
`endif
    wait_rsp(4);
    checks++; if (rsp_who.size() !== 4) begin errors++; $display("FAIL prio_count got %0d exp 4", rsp_who.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rsp_who[k] !== exp_who[k]) begin errors++; $display("FAIL prio_who[%0d] got %0d exp %0d", k, rsp_who[k], exp_who[k]); end
      checks++; if (rsp_val[k] !== exp_q[k]) begin errors++; $display("FAIL prio_sum[%0d] got %0h exp %0h", k, rsp_val[k], exp_q[k]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    acc_rdy = 1'b1;
    rsp_rdy = '1;
    test_reset();
    test_single();
    test_two_requesters();
    test_back_to_back();
    test_rsp_stall();
    test_withdraw();
    test_reset_mid_burst();
    test_priority_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulate_arbiter.md
Name: accumulate_arbiter

Overview:
- Shares one accumulate datapath between N requesters, one whole burst at a time.
- Each requester streams signed arguments and gets back its own sum.
- Grants are round-robin; a grant is held for the entire burst and until that requester accepts its result.
- Sits between N producer streams and the single accumulator's argument and result ports.

Parameters:
- N, 4, number of requesters (2..16).
- ARGW, 32, argument width; must match the accumulator's ARGW.
- RESW, 40, result width; must match the accumulator's RESW.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_stb  input  N  per-requester argument strobe.
- req_dat  input  N*ARGW  per-requester argument; requester i occupies bits [i*ARGW +: ARGW].
- req_rdy  output  N  per-requester argument ready.
- rsp_stb  output  N  per-requester result strobe.
- rsp_dat  output  RESW  result data, shared by all requesters, qualified by rsp_stb.
- rsp_rdy  input  N  per-requester result ready.
- acc_stb  output  1  to accumulator arg_stb.
- acc_dat  output  ARGW  to accumulator arg_dat.
- acc_rdy  input  1  from accumulator arg_rdy.
- acc_res_stb  input  1  from accumulator res_stb.
- acc_res_dat  input  RESW  from accumulator res_dat.
- acc_res_rdy  output  1  to accumulator res_rdy.

Behaviour:
- Burst definition (accumulator contract):
  - A burst is one or more accepted beats (stb&rdy) followed by a cycle with stb low.
  - The accumulator returns one result per burst, no earlier than 2 cycles after stb drops.
- Registered state:
  - state: IDLE, BURST or DRAIN.
  - gnt: index of the granted requester.
  - ptr: round-robin pointer.
  - seen: at least one beat accepted in the current burst.
- Reset (rst low, asynchronous):
  - state=IDLE, gnt=0, ptr=0, seen=0.
  - All outputs 0: acc_stb, req_rdy, rsp_stb, acc_res_rdy.
  - Reset mid-burst or mid-drain abandons the transaction. The accumulator is reset by the same signal.
- IDLE:
  - All outputs 0.
  - If any req_stb bit is set, choose the first set bit at or after ptr, wrapping modulo N.
  - Register it into gnt, clear seen, go to BURST.
  - Grant latency: 1 cycle from req_stb to acc_stb.
- BURST (combinational forwarding):
  - acc_stb = req_stb[gnt].
  - acc_dat = req_dat[gnt].
  - req_rdy[gnt] = acc_rdy; all other req_rdy bits = 0.
  - seen <= 1 on any accepted beat.
  - req_stb[gnt] low and seen=1: go to DRAIN (normal burst end). acc_stb is already low this cycle, which terminates the accumulator burst.
  - req_stb[gnt] low and seen=0: withdrawn before any beat; go to IDLE and set ptr=gnt+1 mod N. No result is expected.
  - Requests from other requesters are ignored until the grant is released. No preemption.
- DRAIN:
  - acc_stb=0 and all req_rdy=0.
  - rsp_stb[gnt] = acc_res_stb; all other rsp_stb bits = 0.
  - rsp_dat = acc_res_dat.
  - acc_res_rdy = rsp_rdy[gnt].
  - On acc_res_stb & rsp_rdy[gnt]: go to IDLE and set ptr=gnt+1 mod N.
  - This ensures at least one idle argument cycle between bursts, so bursts from different requesters are never merged.
- Throughput: back-to-back beats at 1/cycle within a burst. Minimum gap between bursts of different requesters is DRAIN duration + 1 IDLE cycle.
- rsp_dat is driven from acc_res_dat in all states; it is meaningful only under rsp_stb.
- Simultaneous events:
  - A new request arriving in the same cycle as the DRAIN handshake is considered in the following IDLE cycle, using the updated ptr.
  - Arithmetic is performed entirely by the accumulator; this block performs no width conversion.
- Requester obligations, which the bench checks:
  - Hold req_stb and req_dat stable until accepted.
  - Keep req_stb low for at least one cycle to end a burst.

Optional Feature:
- Macro: ACCUMULATE_ARBITER_FIXED_PRIORITY_EN.
- Defined: IDLE always selects the lowest-index asserted req_stb; ptr is not used (fixed priority, index 0 highest).
- Undefined: round-robin as described above.

Test Plan:
- Single requester 1 sends beats 5, -3, 10, then drops stb → acc_stb first asserts 1 cycle after req_stb[1]; rsp_stb[1] asserts with rsp_dat=12; rsp_stb[0,2,3] stay 0.
- Requesters 0 and 2 request together from reset (ptr=0) → 0 served first with sum 7 (beats 3,4); then 2 served with sum -1 (beats 1,-2); after that, ptr=3.
- All four requesters hold stb continuously, two-beat bursts of 1,1 → grants in order 0,1,2,3,0; each gets rsp_dat=2; never two grants at once; acc_stb low at least one cycle between bursts.
- Requester 0 stalls result with rsp_rdy[0]=0 for 5 cycles while requester 1 requests → req_rdy[1] stays 0 until the rsp handshake completes; then requester 1 is granted.
- Requester 3 is granted, then drops stb before any beat (acc_rdy held 0) → return to IDLE, no rsp_stb, ptr=0.
- Assert rst low mid-burst (after 2 beats) → all outputs 0 immediately (asynchronously); after release, a fresh burst 4,4 from requester 2 returns 8.
- With ACCUMULATE_ARBITER_FIXED_PRIORITY_EN: requesters 1 and 3 continuously requesting → requester 1 wins every arbitration.
